rom_port_arbiter: RTL
=====================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single instruction ROM port between the core's instruction-fetch (IF) requester and a
//  load (LS) requester reading constants from ROM. It sits between riscv and inst_rom. Each cycle it
//  grants at most one request and returns registered read data with a fixed 1-cycle latency.
//  LS has priority, and an age counter guarantees that IF is never starved.
// PARAMETERS
//  ADDR_W    32  address width of both requesters and the ROM
//  DATA_W    32  ROM word width
//  MAX_WAIT  4   consecutive denied IF cycles before IF is forcibly granted (1..15)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  if_req_i     in   1       fetch request; held with if_addr_i until granted
//  if_addr_i    in   ADDR_W  fetch byte address
//  if_flush_i   in   1       discard any fetch response due next cycle (branch redirect)
//  if_gnt_o     out  1       fetch accepted this cycle (combinational)
//  if_rvalid_o  out  1       fetch data valid (registered)
//  if_rdata_o   out  DATA_W  fetch data (registered)
//  ls_req_i     in   1       load request; held with ls_addr_i until granted
//  ls_addr_i    in   ADDR_W  load byte address
//  ls_gnt_o     out  1       load accepted this cycle (combinational)
//  ls_rvalid_o  out  1       load data valid (registered)
//  ls_rdata_o   out  DATA_W  load data (registered)
//  rom_ce_o     out  1       ROM chip enable (combinational, equals any grant)
//  rom_addr_o   out  ADDR_W  ROM address (combinational mux of the winner; 0 when idle)
//  rom_data_i   in   DATA_W  ROM read data; combinational from rom_addr_o
// BEHAVIOUR
//  - Reset (async, rst_n=0): if_rvalid_o=0, ls_rvalid_o=0, if_rdata_o=0, ls_rdata_o=0, wait_cnt=0.
//    Combinational outputs follow the inputs, but both grants are forced to 0 while rst_n=0.
//  - Arbitration in cycle N:
//      force_if = (wait_cnt >= MAX_WAIT) && if_req_i
//      grant IF if force_if, or if (if_req_i && !ls_req_i); otherwise grant LS if ls_req_i.
//      Exactly one grant, or none; never both.
//  - wait_cnt (4 bit): +1 when if_req_i=1 and IF is not granted; clears to 0 on an IF grant or when
//    if_req_i=0. It saturates at MAX_WAIT.
//  - Latency: on a grant in cycle N, rom_data_i is sampled at the end of N into the winner's rdata
//    register, and that requester's rvalid is 1 in cycle N+1. The rvalid pulse lasts 1 cycle unless
//    there is another grant. The rdata register holds its last value when there is no grant.
//    Back-to-back grants give one word per cycle.
//  - Flush: if_flush_i=1 in cycle N clears if_rvalid_o in cycle N+1, even if IF was granted in N.
//    if_flush_i has no effect on grants, wait_cnt or the LS side.
//  - Address: rom_addr_o = winner address, passed through unaltered (ROM does its own word index).
//  - Simultaneous IF+LS with wait_cnt<MAX_WAIT: LS wins and the IF request stays pending.
//  - Reset mid-transaction: any pending rvalid is dropped. Requesters must re-issue after reset.
//  - No internal FSM beyond the counter and the rvalid/rdata registers; no data path through to reset.
// STRUCTURE
//  - Shared package riscv_defs: ADDR_W/DATA_W defaults and the ROM word-width constants.
//  - One sub-module, rr_age_counter: the saturating wait counter plus the force_if compare.
//  - Top-level instantiation: riscv drives if_*/ls_*; inst_rom connects to rom_*.
// TESTING
//  1 Reset: rst_n=0 while if_req_i=1 -> no grants, all rvalid=0, rdata=0; release -> IF granted next edge.
//  2 IF only, addr 0x0,0x4,0x8 on consecutive cycles -> if_gnt_o=1 each cycle; if_rvalid_o=1 on cycles
//    1..3 with ROM words 0,1,2; ls_rvalid_o stays 0.
//  3 Both requesting, MAX_WAIT=4, LS held high -> LS granted cycles 0..3; IF forced on cycle 4;
//    wait_cnt=0 after cycle 4; LS granted again on cycle 5.
//  4 IF granted at 0x10 with if_flush_i=1 in the same cycle -> if_rvalid_o=0 next cycle;
//    if_rdata_o content is don't-care.
//  5 Alternating LS@0x20 and IF@0x24 -> each rvalid arrives exactly 1 cycle after its grant with the
//    correct word; never both grants at once (assertion).
//  6 rst_n asserted the cycle after an LS grant -> ls_rvalid_o is 0 immediately (async), with no
//    stale pulse after release.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// Shared ROM/core constants used by the ROM port arbiter and its age counter.
package riscv_defs;
   localparam int ADDR_W         = 32;
   localparam int DATA_W         = 32;
   localparam int ROM_WORD_BYTES = DATA_W / 8;
   localparam int ROM_WORD_LSB   = $clog2(ROM_WORD_BYTES);
   localparam int CNT_W          = 4;
endpackage

// File: rtl/rom_port_arbiter_age_counter.sv
// Counts consecutive cycles a pending fetch was denied; raises force_if_o once the limit is reached.
module rr_age_counter
   import riscv_defs::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req_i,
   input  logic if_gnt_i,
   output logic force_if_o
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!if_req_i || if_gnt_i) cnt_d = '0;
      else if (cnt_q < LIMIT)    cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign force_if_o = if_req_i && (cnt_q >= LIMIT);
endmodule

// File: rtl/rom_port_arbiter.sv
// Single ROM port shared by fetch and load; LS priority with IF anti-starvation, 1-cycle read latency.
module rom_port_arbiter
   import riscv_defs::*;
#(
   parameter int ADDR_W   = riscv_defs::ADDR_W,
   parameter int DATA_W   = riscv_defs::DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              ls_req_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i
);
   logic              force_if;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

   rr_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req_i   (if_req_i),
      .if_gnt_i   (if_gnt_o),
      .force_if_o (force_if)
   );

   // Grants are gated by rst_n so nothing reaches the ROM while reset is held.
   assign if_gnt_o   = rst_n && (force_if || (if_req_i && !ls_req_i));
   assign ls_gnt_o   = rst_n && ls_req_i && !if_gnt_o;
   assign rom_ce_o   = if_gnt_o || ls_gnt_o;
   assign rom_addr_o = if_gnt_o ? if_addr_i : (ls_gnt_o ? ls_addr_i : '0);

   always_comb begin
      if_rvalid_d = if_gnt_o && !if_flush_i;
      ls_rvalid_d = ls_gnt_o;
      if_rdata_d  = if_gnt_o ? rom_data_i : if_rdata_q;
      ls_rdata_d  = ls_gnt_o ? rom_data_i : ls_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign ls_rdata_o  = ls_rdata_q;
endmodule
